// File: rtl/j1x_pkg.sv
// j1x shared definitions: opcode classes, ALU op codes,
// instruction field positions and fault flag indices.
package j1x_pkg;

    localparam logic [2:0] OP_JMP  = 3'b000;
    localparam logic [2:0] OP_CJMP = 3'b001;
    localparam logic [2:0] OP_CALL = 3'b010;
    localparam logic [2:0] OP_ALU  = 3'b011;

    localparam int B_LIT = 15;
    localparam int B_RPC = 12;
    localparam int B_TN  = 7;
    localparam int B_TR  = 6;
    localparam int B_NT  = 5;

    localparam int F_RS_OVF = 3;
    localparam int F_RS_UNF = 2;
    localparam int F_DS_OVF = 1;
    localparam int F_DS_UNF = 0;

    typedef enum logic [3:0] {
        A_T, A_N, A_ADD, A_AND, A_OR, A_XOR, A_INV, A_EQ,
        A_LT, A_SHR, A_DEC, A_R, A_MEM, A_SHL, A_DEPTH, A_ULT
    } alu_op_e;

endpackage

// File: rtl/j1x_core_stack.sv
// j1x stack: pointer register plus RAM with async top read;
// writes land at ptr+delta, all updates gated by i_en.
module j1x_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_we,
    input  logic [1:0]       i_delta,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [DEPTH-1:0] o_ptr,
    output logic [WIDTH-1:0] o_top,
    output logic             o_ovf,
    output logic             o_unf
);

    logic [WIDTH-1:0] r_mem [2**DEPTH];
    logic [DEPTH-1:0] r_ptr;
    logic [DEPTH-1:0] w_nptr;

    assign w_nptr = r_ptr + DEPTH'($signed(i_delta));
    assign o_ptr  = r_ptr;
    assign o_top  = r_mem[r_ptr];
    assign o_ovf  = (i_delta == 2'b01) && (r_ptr == '1);
    assign o_unf  = ((i_delta == 2'b11) && (r_ptr == '0)) ||
                    ((i_delta == 2'b10) && (r_ptr < DEPTH'(2)));

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= w_nptr;
        end
    end

    // RAM contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            r_mem[w_nptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/j1x_core.sv
// j1x_core: parametrised J1 stack CPU with stalling I/O
// handshake, byte-address return stack and sticky stack faults.
module j1x_core
    import j1x_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 4,
    parameter int FAULT_HALT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [12:0]      pc,
    input  logic [15:0]      instr,
    output logic             io_we,
    output logic             io_re,
    output logic [WIDTH-1:0] io_ptr,
    output logic [WIDTH-1:0] io_out,
    input  logic [WIDTH-1:0] io_in,
    input  logic             io_ready,
    output logic [3:0]       fault,
    output logic             halted
);

    logic [12:0]      r_pc;
    logic [WIDTH-1:0] r_t;
    logic [3:0]       r_fault;

    logic             w_lit, w_jmp, w_cjmp, w_call, w_alu_i;
    alu_op_e          w_aop;
    logic             w_halted, w_stall, w_commit;
    logic [12:0]      w_pc_inc, w_pc_nxt;
    logic [WIDTH-1:0] w_n, w_r, w_alu, w_t_nxt, w_rs_wd;
    logic [DEPTH-1:0] w_dsp, w_rsp;
    logic [1:0]       w_ds_d, w_rs_d;
    logic             w_ds_we, w_rs_we;
    logic             w_ds_ovf, w_ds_unf, w_rs_ovf, w_rs_unf;

    assign w_lit   = instr[B_LIT];
    assign w_jmp   = !w_lit && (instr[15:13] == OP_JMP);
    assign w_cjmp  = !w_lit && (instr[15:13] == OP_CJMP);
    assign w_call  = !w_lit && (instr[15:13] == OP_CALL);
    assign w_alu_i = !w_lit && (instr[15:13] == OP_ALU);
    assign w_aop   = alu_op_e'(instr[11:8]);

    assign w_halted = (FAULT_HALT != 0) && (|r_fault);
    assign io_re    = rst_n && !w_halted && w_alu_i && (w_aop == A_MEM);
    assign io_we    = rst_n && !w_halted && w_alu_i && instr[B_NT];
    assign w_stall  = (io_re || io_we) && !io_ready;
    assign w_commit = rst_n && !w_halted && !w_stall;
    assign w_pc_inc = r_pc + 13'd1;

    always_comb begin
        w_alu = r_t;
        unique case (w_aop)
            A_T:     w_alu = r_t;
            A_N:     w_alu = w_n;
            A_ADD:   w_alu = r_t + w_n;
            A_AND:   w_alu = r_t & w_n;
            A_OR:    w_alu = r_t | w_n;
            A_XOR:   w_alu = r_t ^ w_n;
            A_INV:   w_alu = ~r_t;
            A_EQ:    w_alu = (w_n == r_t) ? '1 : '0;
            A_LT:    w_alu = ($signed(w_n) < $signed(r_t)) ? '1 : '0;
            A_SHR:   w_alu = w_n >> 1;
            A_DEC:   w_alu = r_t - WIDTH'(1);
            A_R:     w_alu = w_r;
            A_MEM:   w_alu = io_in;
            A_SHL:   w_alu = w_n << 1;
            A_DEPTH: w_alu = WIDTH'({w_rsp, w_dsp});
            A_ULT:   w_alu = (w_n < r_t) ? '1 : '0;
        endcase
    end

    always_comb begin
        w_t_nxt  = r_t;
        w_pc_nxt = w_pc_inc;
        w_ds_d   = 2'b00;
        w_rs_d   = 2'b00;
        w_ds_we  = 1'b0;
        w_rs_we  = 1'b0;
        w_rs_wd  = r_t;
        unique case (1'b1)
            w_lit: begin
                w_t_nxt = WIDTH'(instr[14:0]);
                w_ds_d  = 2'b01;
                w_ds_we = 1'b1;
            end
            w_jmp: w_pc_nxt = instr[12:0];
            w_cjmp: begin
                if (r_t == '0) w_pc_nxt = instr[12:0];
                w_t_nxt = w_n;
                w_ds_d  = 2'b11;
            end
            // return stack holds byte addresses
            w_call: begin
                w_pc_nxt = instr[12:0];
                w_rs_d   = 2'b01;
                w_rs_we  = 1'b1;
                w_rs_wd  = WIDTH'({w_pc_inc, 1'b0});
            end
            w_alu_i: begin
                w_t_nxt = w_alu;
                w_ds_d  = instr[1:0];
                w_rs_d  = instr[3:2];
                w_ds_we = instr[B_TN];
                w_rs_we = instr[B_TR];
                if (instr[B_RPC]) w_pc_nxt = w_r[13:1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc    <= '0;
            r_t     <= '0;
            r_fault <= '0;
        end else if (w_commit) begin
            r_pc    <= w_pc_nxt;
            r_t     <= w_t_nxt;
            r_fault <= r_fault |
                       {w_rs_ovf, w_rs_unf, w_ds_ovf, w_ds_unf};
        end
    end

    j1x_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ds (
        .clk     (clk),
        .i_rst_n (rst_n),
        .i_en    (w_commit),
        .i_we    (w_ds_we),
        .i_delta (w_ds_d),
        .i_wdata (r_t),
        .o_ptr   (w_dsp),
        .o_top   (w_n),
        .o_ovf   (w_ds_ovf),
        .o_unf   (w_ds_unf)
    );

    j1x_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rs (
        .clk     (clk),
        .i_rst_n (rst_n),
        .i_en    (w_commit),
        .i_we    (w_rs_we),
        .i_delta (w_rs_d),
        .i_wdata (w_rs_wd),
        .o_ptr   (w_rsp),
        .o_top   (w_r),
        .o_ovf   (w_rs_ovf),
        .o_unf   (w_rs_unf)
    );

    assign pc     = r_pc;
    assign io_ptr = r_t;
    assign io_out = w_n;
    assign fault  = r_fault;
    assign halted = w_halted;

endmodule
